// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared widths, encodings and bus layouts for the EX stage
package exe_stage_pkg;

    localparam int DS_ES_W  = 156;
    localparam int ES_MS_W  = 77;
    localparam int RAW_ES_W = 38;

    // One-hot alu_op bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 6;
    localparam int ALU_NOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // Access size, shared by st_size and data_sram_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // load_op: bit2 word, bit0 half, bit1 zero-extend
    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_HU = 3'b011;
    localparam logic [2:0] LD_W  = 3'b100;

    typedef struct packed {
        logic [11:0] alu_op;
        logic        div_en;
        logic        div_signed;
        logic        div_rem;
        logic        mem_we;
        logic [1:0]  st_size;
        logic        res_from_mem;
        logic [2:0]  load_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] st_data;
        logic [31:0] pc;
    } ds_es_bus_t;

    typedef struct packed {
        logic        mem_we;
        logic [2:0]  load_op;
        logic [1:0]  addr_lo;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] es_result;
        logic [31:0] pc;
    } es_ms_bus_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] result;
    } raw_es_bus_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [1:0] load_size(input logic [2:0] op);
        if (op[2]) return SZ_W;
        if (op[0]) return SZ_H;
        return SZ_B;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - decode/memory/SRAM-facing signals of the EX stage
interface exe_stage_if
    import exe_stage_pkg::*;
();
    logic                ds_to_es_valid;
    logic [DS_ES_W-1:0]  ds_to_es_bus;
    logic                es_allowin;
    logic                ms_allowin;
    logic                es_to_ms_valid;
    logic [ES_MS_W-1:0]  es_to_ms_bus;
    logic                data_sram_req;
    logic                data_sram_wr;
    logic [1:0]          data_sram_size;
    logic [3:0]          data_sram_wstrb;
    logic [31:0]         data_sram_addr;
    logic [31:0]         data_sram_wdata;
    logic                data_sram_addr_ok;
    logic [RAW_ES_W-1:0] raw_es_bus;
    logic                blk_es_load;

    // The EX stage itself
    modport master (
        input  ds_to_es_valid, ds_to_es_bus, ms_allowin, data_sram_addr_ok,
        output es_allowin, es_to_ms_valid, es_to_ms_bus,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
        output data_sram_addr, data_sram_wdata, raw_es_bus, blk_es_load
    );

    // Surrounding pipeline and memory
    modport slave (
        output ds_to_es_valid, ds_to_es_bus, ms_allowin, data_sram_addr_ok,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
        input  data_sram_addr, data_sram_wdata, raw_es_bus, blk_es_load
    );
endinterface

// File: rtl/exe_stage_div_iter.sv
// rtl/exe_stage_div_iter.sv - 32-iteration restoring radix-2 divider with signed fixup
module exe_stage_div_iter
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        ack_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);
    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;        // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [31:0] dvd_raw_q;
    logic [31:0] quo_res_q;
    logic [31:0] rem_res_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        dvs_zero_q;
    logic        done_q;

    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] quo_d;
    logic [31:0] rem_d;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // One restoring step on magnitudes, plus sign/zero-divisor fixup of that step's result
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
        fits      = !diff[32];
        rem_d     = fits ? diff[31:0] : rem_shift[31:0];
        quo_d     = {quo_q[30:0], fits};
        quo_fix   = dvs_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_d : quo_d);
        rem_fix   = dvs_zero_q ? dvd_raw_q     : (neg_rem_q ? -rem_d : rem_d);
    end

    // IDLE -> BUSY for 32 steps -> DONE, held until the result is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dvd_raw_q  <= '0;
            quo_res_q  <= '0;
            rem_res_q  <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dvs_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        state_q    <= DIV_BUSY;
                        cnt_q      <= '0;
                        quo_q      <= (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
                        rem_q      <= '0;
                        dvs_q      <= (signed_i && divisor_i[31]) ? -divisor_i : divisor_i;
                        neg_quo_q  <= signed_i && (dividend_i[31] ^ divisor_i[31]);
                        neg_rem_q  <= signed_i && dividend_i[31];
                        dvs_zero_q <= (divisor_i == 32'd0);
                        dvd_raw_q  <= dividend_i;
                    end
                end
                DIV_BUSY: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q   <= DIV_DONE;
                        done_q    <= 1'b1;
                        quo_res_q <= quo_fix;
                        rem_res_q <= rem_fix;
                    end
                end
                DIV_DONE: begin
                    if (ack_i) begin
                        state_q <= DIV_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign done_o      = done_q;
    assign quotient_o  = quo_res_q;
    assign remainder_o = rem_res_q;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, data SRAM request, iterative divide
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.master es_io
);
    logic       es_valid_q;
    logic       es_valid_d;
    ds_es_bus_t es_bus_q;

    logic        es_ready_go;
    logic        es_allowin;
    logic        es_to_ms_valid;
    logic        memop;
    logic        sram_req;
    logic [31:0] mem_addr;
    logic [31:0] alu_res;
    logic [31:0] es_result;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_wdata;
    logic [1:0]  sram_size;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    logic [31:0] src1;
    logic [31:0] src2;
    logic [11:0] op;

    assign src1 = es_bus_q.src1;
    assign src2 = es_bus_q.src2;
    assign op   = es_bus_q.alu_op;

    assign es_valid_d = es_allowin ? es_io.ds_to_es_valid : es_valid_q;

    // Occupancy of the stage
    always_ff @(posedge clk) begin
        if (reset) es_valid_q <= 1'b0;
        else       es_valid_q <= es_valid_d;
    end

    // Instruction payload, captured only when something actually enters
    always_ff @(posedge clk) begin
        if (es_io.ds_to_es_valid && es_allowin) es_bus_q <= ds_es_bus_t'(es_io.ds_to_es_bus);
    end

    // One-hot ALU; shift amount comes from src1, shifted value is src2
    always_comb begin
        alu_res = ({32{op[ALU_ADD]}}  & (src1 + src2))
                | ({32{op[ALU_SUB]}}  & (src1 - src2))
                | ({32{op[ALU_SLT]}}  & {31'd0, ($signed(src1) < $signed(src2))})
                | ({32{op[ALU_SLTU]}} & {31'd0, (src1 < src2)})
                | ({32{op[ALU_AND]}}  & (src1 & src2))
                | ({32{op[ALU_OR]}}   & (src1 | src2))
                | ({32{op[ALU_XOR]}}  & (src1 ^ src2))
                | ({32{op[ALU_NOR]}}  & ~(src1 | src2))
                | ({32{op[ALU_SLL]}}  & (src2 << src1[4:0]))
                | ({32{op[ALU_SRL]}}  & (src2 >> src1[4:0]))
                | ({32{op[ALU_SRA]}}  & $unsigned($signed(src2) >>> src1[4:0]))
                | ({32{op[ALU_LUI]}}  & {src2[15:0], 16'd0});
    end

    assign memop    = es_bus_q.mem_we || es_bus_q.res_from_mem;
    assign mem_addr = src1 + src2;
    // Held back while MEM is full so that an accepted request always has somewhere to go
    assign sram_req = es_valid_q && memop && es_io.ms_allowin;

    // Store lane replication and byte enables; loads never write
    always_comb begin
        sram_size  = load_size(es_bus_q.load_op);
        sram_wstrb = 4'b0000;
        sram_wdata = es_bus_q.st_data;
        if (es_bus_q.mem_we) begin
            sram_size = es_bus_q.st_size;
            case (es_bus_q.st_size)
                SZ_B: begin
                    sram_wstrb = 4'b0001 << mem_addr[1:0];
                    sram_wdata = {4{es_bus_q.st_data[7:0]}};
                end
                SZ_H: begin
                    sram_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
                    sram_wdata = {2{es_bus_q.st_data[15:0]}};
                end
                default: begin
                    sram_wstrb = 4'b1111;
                    sram_wdata = es_bus_q.st_data;
                end
            endcase
        end
    end

    // Completion condition per instruction class
    always_comb begin
        if (es_bus_q.div_en)  es_ready_go = div_done;
        else if (memop)       es_ready_go = sram_req && es_io.data_sram_addr_ok;
        else                  es_ready_go = 1'b1;
    end

    assign es_allowin     = !es_valid_q || (es_ready_go && es_io.ms_allowin);
    assign es_to_ms_valid = es_valid_q && es_ready_go;

    exe_stage_div_iter div_iter (
        .clk         (clk),
        .reset       (reset),
        .start_i     (es_valid_q && es_bus_q.div_en),
        .signed_i    (es_bus_q.div_signed),
        .dividend_i  (src1),
        .divisor_i   (src2),
        .ack_i       (es_to_ms_valid && es_io.ms_allowin),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign es_result = es_bus_q.div_en ? (es_bus_q.div_rem ? div_rem : div_quo) : alu_res;

    assign es_io.es_allowin      = es_allowin;
    assign es_io.es_to_ms_valid  = es_to_ms_valid;
    assign es_io.es_to_ms_bus    = {es_bus_q.mem_we, es_bus_q.load_op, mem_addr[1:0],
                                    es_bus_q.res_from_mem, es_bus_q.gr_we, es_bus_q.dest,
                                    es_result, es_bus_q.pc};
    assign es_io.data_sram_req   = sram_req;
    assign es_io.data_sram_wr    = es_bus_q.mem_we;
    assign es_io.data_sram_size  = sram_size;
    assign es_io.data_sram_wstrb = sram_wstrb;
    assign es_io.data_sram_addr  = mem_addr;
    assign es_io.data_sram_wdata = sram_wdata;
    assign es_io.raw_es_bus      = {es_bus_q.gr_we && es_valid_q, es_bus_q.dest, es_result};
    // Loads and unfinished divides have no forwardable result yet
    assign es_io.blk_es_load     = es_valid_q &&
                                   (es_bus_q.res_from_mem || (es_bus_q.div_en && !div_done));

endmodule
